// File: rtl/spi_device_core.sv
// SPI device (slave) with a register-mapped RX FIFO, a single-byte TX holding register and interrupts.
// SPI pins are synchronized into clk_i; every SPI event is derived from synchronized sclk edges.
module spi_device_core #(
    parameter int RX_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [7:0]  addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  be_i,
    input  logic        we_i,
    input  logic        re_i,
    output logic [31:0] rdata_o,
    output logic        error_o,
    output logic        intr_o,
    input  logic        sclk_i,
    input  logic        ss_ni,
    input  logic        sd_i,
    output logic        sd_o,
    output logic        sd_oe_o
);

    localparam int PTR_W = $clog2(RX_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [7:0] ADDR_CTRL   = 8'h00;
    localparam logic [7:0] ADDR_STATUS = 8'h04;
    localparam logic [7:0] ADDR_RXDATA = 8'h08;
    localparam logic [7:0] ADDR_TXDATA = 8'h0C;
    localparam logic [7:0] ADDR_INTR   = 8'h10;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic sclk_meta, sclk_sync, sclk_prev;
    logic ss_meta, ss_sync, ss_prev;
    logic sd_meta, sd_sync;

    logic [6:0] ctrl_q;
    logic [2:0] intr_state_q;
    logic [7:0] tx_hold_q;
    logic       tx_hold_valid_q;
    logic [7:0] tx_shift_q;
    logic [7:0] rx_shift_q;
    logic [2:0] bit_cnt_q;

    logic [7:0]       fifo_mem [RX_DEPTH];
    logic [PTR_W-1:0] wptr_q, rptr_q;
    logic [CNT_W-1:0] rx_count_q;

    logic en, cpol, cpha, lsbf;
    assign en   = ctrl_q[0];
    assign cpol = ctrl_q[1];
    assign cpha = ctrl_q[2];
    assign lsbf = ctrl_q[3];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sclk_meta <= 1'b0;
            sclk_sync <= 1'b0;
            sclk_prev <= 1'b0;
            ss_meta   <= 1'b1;
            ss_sync   <= 1'b1;
            ss_prev   <= 1'b1;
            sd_meta   <= 1'b0;
            sd_sync   <= 1'b0;
        end else begin
            sclk_meta <= sclk_i;
            sclk_sync <= sclk_meta;
            sclk_prev <= sclk_sync;
            ss_meta   <= ss_ni;
            ss_sync   <= ss_meta;
            ss_prev   <= ss_sync;
            sd_meta   <= sd_i;
            sd_sync   <= sd_meta;
        end
    end

    logic sclk_rise, sclk_fall, ss_fall;
    logic lead_edge, trail_edge, sample_edge, shift_edge;
    assign sclk_rise   = sclk_sync & ~sclk_prev;
    assign sclk_fall   = ~sclk_sync & sclk_prev;
    assign ss_fall     = ss_prev & ~ss_sync;
    assign lead_edge   = cpol ? sclk_fall : sclk_rise;
    assign trail_edge  = cpol ? sclk_rise : sclk_fall;
    assign sample_edge = cpha ? trail_edge : lead_edge;
    assign shift_edge  = cpha ? lead_edge : trail_edge;

    // Register access decode
    logic mapped, access_err, wr_ok, rd_ok;
    assign mapped     = (addr_i == ADDR_CTRL) || (addr_i == ADDR_STATUS) ||
                        (addr_i == ADDR_RXDATA) || (addr_i == ADDR_TXDATA) ||
                        (addr_i == ADDR_INTR);
    assign access_err = ((re_i || we_i) && !mapped) ||
                        (we_i && ((addr_i == ADDR_STATUS) || (addr_i == ADDR_RXDATA))) ||
                        (re_i && (addr_i == ADDR_TXDATA));
    assign error_o    = access_err;
    assign wr_ok      = we_i && !access_err;
    assign rd_ok      = re_i && !access_err;

    logic ctrl_wr, tx_wr, intr_wr;
    assign ctrl_wr = wr_ok && (addr_i == ADDR_CTRL) && be_i[0];
    assign tx_wr   = wr_ok && (addr_i == ADDR_TXDATA) && be_i[0];
    assign intr_wr = wr_ok && (addr_i == ADDR_INTR) && be_i[0];

    logic rx_empty, rx_full;
    assign rx_empty = (rx_count_q == '0);
    assign rx_full  = (rx_count_q == CNT_W'(RX_DEPTH));

    logic pop;
    assign pop = rd_ok && (addr_i == ADDR_RXDATA) && !rx_empty;

    // Serial FSM: state transitions and the tx reload request on entry
    logic load_tx;
    always_comb begin
        state_d = state_q;
        load_tx = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ss_fall && en) begin
                    state_d = ST_SHIFT;
                    load_tx = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (ss_sync || !en) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    logic active, leaving, sample_now, shift_now, byte_done, reload;
    logic push_ok, ovf_set, txe_set;
    logic [7:0] rx_next;
    assign active     = (state_q == ST_SHIFT) && (state_d == ST_SHIFT);
    assign leaving    = (state_q == ST_SHIFT) && (state_d == ST_IDLE);
    assign sample_now = active && sample_edge;
    // No shift at bit 0: that edge only presents the freshly loaded first bit.
    assign shift_now  = active && shift_edge && (bit_cnt_q != 3'd0);
    assign byte_done  = sample_now && (bit_cnt_q == 3'd7);
    assign reload     = load_tx || byte_done;
    assign rx_next    = lsbf ? {sd_sync, rx_shift_q[7:1]} : {rx_shift_q[6:0], sd_sync};
    // A simultaneous pop frees a slot, so a push into a full FIFO is still accepted then.
    assign push_ok    = byte_done && (!rx_full || pop);
    assign ovf_set    = byte_done && rx_full && !pop;
    assign txe_set    = reload && tx_hold_valid_q;

    logic [2:0] intr_set, intr_clr, intr_next;
    assign intr_set  = {ovf_set, txe_set, push_ok};
    assign intr_clr  = intr_wr ? wdata_i[2:0] : 3'b000;
    assign intr_next = (intr_state_q & ~intr_clr) | intr_set;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= ST_IDLE;
            ctrl_q          <= '0;
            intr_state_q    <= '0;
            intr_o          <= 1'b0;
            tx_hold_q       <= '0;
            tx_hold_valid_q <= 1'b0;
            tx_shift_q      <= '0;
            rx_shift_q      <= '0;
            bit_cnt_q       <= '0;
            wptr_q          <= '0;
            rptr_q          <= '0;
            rx_count_q      <= '0;
        end else begin
            state_q      <= state_d;
            intr_state_q <= intr_next;
            intr_o       <= |(intr_state_q & ctrl_q[6:4]);

            if (ctrl_wr) ctrl_q <= wdata_i[6:0];

            if (load_tx || leaving) begin
                bit_cnt_q  <= '0;
                rx_shift_q <= '0;
            end else if (sample_now) begin
                bit_cnt_q  <= bit_cnt_q + 3'd1;
                rx_shift_q <= rx_next;
            end

            if (reload)
                tx_shift_q <= tx_hold_valid_q ? tx_hold_q : 8'hFF;
            else if (shift_now)
                tx_shift_q <= lsbf ? {1'b0, tx_shift_q[7:1]} : {tx_shift_q[6:0], 1'b0};

            // A new write wins over a coinciding reload, which already took the old byte.
            if (tx_wr) begin
                tx_hold_q       <= wdata_i[7:0];
                tx_hold_valid_q <= 1'b1;
            end else if (txe_set) begin
                tx_hold_valid_q <= 1'b0;
            end

            if (push_ok) wptr_q <= wptr_q + PTR_W'(1);
            if (pop)     rptr_q <= rptr_q + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   rx_count_q <= rx_count_q + CNT_W'(1);
                2'b01:   rx_count_q <= rx_count_q - CNT_W'(1);
                default: rx_count_q <= rx_count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) fifo_mem[wptr_q] <= rx_next;
    end

    assign sd_oe_o = (state_q == ST_SHIFT);
    assign sd_o    = sd_oe_o && (lsbf ? tx_shift_q[0] : tx_shift_q[7]);

    logic [4:0] rx_count5;
    assign rx_count5 = 5'(rx_count_q);

    always_comb begin
        rdata_o = '0;
        if (re_i) begin
            case (addr_i)
                ADDR_CTRL:   rdata_o = {25'd0, ctrl_q};
                ADDR_STATUS: rdata_o = {20'd0, (state_q == ST_SHIFT), tx_hold_valid_q,
                                        rx_full, rx_empty, 3'd0, rx_count5};
                ADDR_RXDATA: rdata_o = rx_empty ? 32'd0 : {24'd0, fifo_mem[rptr_q]};
                ADDR_INTR:   rdata_o = {29'd0, intr_state_q};
                default:     rdata_o = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_device_core.sv
// Directed bench for spi_device_core: register access, SPI modes 0 and 3,
// FIFO overflow, aborted bytes, access errors and asynchronous reset mid-byte.
module tb_spi_device_core;

    localparam int HALF = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  be = '0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [31:0] rdata;
    logic        error;
    logic        intr;
    logic        sclk = 1'b0;
    logic        ss_n = 1'b1;
    logic        sd_in = 1'b0;
    logic        miso;
    logic        miso_oe;

    int n_vec = 0;
    int n_err = 0;

    logic m_cpol = 1'b0;
    logic m_cpha = 1'b0;
    logic m_lsbf = 1'b0;

    spi_device_core #(.RX_DEPTH(4)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .addr_i  (addr),
        .wdata_i (wdata),
        .be_i    (be),
        .we_i    (we),
        .re_i    (re),
        .rdata_o (rdata),
        .error_o (error),
        .intr_o  (intr),
        .sclk_i  (sclk),
        .ss_ni   (ss_n),
        .sd_i    (sd_in),
        .sd_o    (miso),
        .sd_oe_o (miso_oe)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic reg_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] b,
                          input logic exp_err, input string tag);
        @(negedge clk);
        addr = a; wdata = d; be = b; we = 1'b1;
        #1;
        check_val(tag, {31'd0, error}, {31'd0, exp_err});
        @(negedge clk);
        we = 1'b0; be = '0;
    endtask

    task automatic reg_rd(input logic [7:0] a, output logic [31:0] d, output logic e);
        @(negedge clk);
        addr = a; re = 1'b1;
        #1;
        d = rdata; e = error;
        @(negedge clk);
        re = 1'b0;
    endtask

    task automatic rd_chk(input logic [7:0] a, input logic [31:0] exp, input string tag);
        logic [31:0] d;
        logic        e;
        reg_rd(a, d, e);
        check_val(tag, d, exp);
    endtask

    task automatic rd_err(input logic [7:0] a, input logic exp_err, input string tag);
        logic [31:0] d;
        logic        e;
        reg_rd(a, d, e);
        check_val(tag, {31'd0, e}, {31'd0, exp_err});
    endtask

    // SPI master: ss_n framed transfer of nbits bits in the mode held in m_cpol/m_cpha/m_lsbf.
    task automatic spi_xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        int idx;
        mi = 8'h00;
        sclk = m_cpol;
        wait_clk(8);
        sd_in = m_lsbf ? mo[0] : mo[7];
        ss_n = 1'b0;
        wait_clk(HALF);
        for (int i = 0; i < nbits; i++) begin
            idx = m_lsbf ? i : 7 - i;
            if (!m_cpha) begin
                mi[idx] = miso;
                sclk = ~m_cpol;
                wait_clk(HALF);
                sclk = m_cpol;
                if (i + 1 < nbits) sd_in = m_lsbf ? mo[i + 1] : mo[6 - i];
                wait_clk(HALF);
            end else begin
                sclk = ~m_cpol;
                sd_in = mo[idx];
                wait_clk(HALF);
                mi[idx] = miso;
                sclk = m_cpol;
                wait_clk(HALF);
            end
        end
        ss_n = 1'b1;
        wait_clk(8);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] mi;

        // Reset state
        wait_clk(3);
        check_val("rst_sd_oe", {31'd0, miso_oe}, 32'd0);
        check_val("rst_sd_o", {31'd0, miso}, 32'd0);
        check_val("rst_intr", {31'd0, intr}, 32'd0);
        rst_n = 1'b1;
        wait_clk(2);
        rd_chk(8'h00, 32'h0000_0000, "rst_ctrl");
        rd_chk(8'h04, 32'h0000_0100, "rst_status");
        rd_chk(8'h10, 32'h0000_0000, "rst_intr_state");

        // Mode 0, TX 0xA5, master sends 0x3C
        m_cpol = 0; m_cpha = 0; m_lsbf = 0;
        reg_wr(8'h00, 32'h01, 4'h1, 1'b0, "m0_ctrl_wr");
        reg_wr(8'h0C, 32'hA5, 4'h1, 1'b0, "m0_tx_wr");
        rd_chk(8'h04, 32'h0000_0500, "m0_status_hold");
        spi_xfer(8'h3C, 8, mi);
        check_val("m0_miso", {24'd0, mi}, 32'hA5);
        rd_chk(8'h04, 32'h0000_0001, "m0_status_cnt1");
        rd_chk(8'h10, 32'h0000_0003, "m0_intr_state");
        rd_chk(8'h08, 32'h0000_003C, "m0_rxdata");
        rd_chk(8'h04, 32'h0000_0100, "m0_status_cnt0");
        reg_wr(8'h10, 32'h7, 4'h1, 1'b0, "m0_intr_clr");
        rd_chk(8'h10, 32'h0000_0000, "m0_intr_cleared");

        // Mode 3 LSB first, holding register empty
        m_cpol = 1; m_cpha = 1; m_lsbf = 1;
        reg_wr(8'h00, 32'h0F, 4'h1, 1'b0, "m3_ctrl_wr");
        spi_xfer(8'h81, 8, mi);
        check_val("m3_miso", {24'd0, mi}, 32'hFF);
        rd_chk(8'h10, 32'h0000_0001, "m3_intr_state");
        rd_chk(8'h08, 32'h0000_0081, "m3_rxdata");
        reg_wr(8'h10, 32'h7, 4'h1, 1'b0, "m3_intr_clr");

        // Overflow with IE_OVF
        m_cpol = 0; m_cpha = 0; m_lsbf = 0;
        reg_wr(8'h00, 32'h41, 4'h1, 1'b0, "ovf_ctrl_wr");
        for (int k = 1; k <= 4; k++) spi_xfer(8'(k * 8'h11), 8, mi);
        check_val("ovf_miso_idle", {24'd0, mi}, 32'hFF);
        rd_chk(8'h04, 32'h0000_0204, "ovf_status_full");
        check_val("ovf_intr_before", {31'd0, intr}, 32'd0);
        spi_xfer(8'h55, 8, mi);
        rd_chk(8'h04, 32'h0000_0204, "ovf_status_after");
        rd_chk(8'h10, 32'h0000_0005, "ovf_intr_state");
        check_val("ovf_intr_set", {31'd0, intr}, 32'd1);
        reg_wr(8'h10, 32'h4, 4'h1, 1'b0, "ovf_clr");
        wait_clk(2);
        check_val("ovf_intr_clr", {31'd0, intr}, 32'd0);
        rd_chk(8'h08, 32'h0000_0011, "ovf_rx0");
        rd_chk(8'h08, 32'h0000_0022, "ovf_rx1");
        rd_chk(8'h08, 32'h0000_0033, "ovf_rx2");
        rd_chk(8'h08, 32'h0000_0044, "ovf_rx3");
        rd_chk(8'h08, 32'h0000_0000, "ovf_rx_empty");
        rd_chk(8'h04, 32'h0000_0100, "ovf_status_empty");
        reg_wr(8'h10, 32'h7, 4'h1, 1'b0, "ovf_clr_all");

        // Aborted byte after 5 bits
        reg_wr(8'h00, 32'h01, 4'h1, 1'b0, "abort_ctrl_wr");
        spi_xfer(8'hF0, 5, mi);
        check_val("abort_sd_oe", {31'd0, miso_oe}, 32'd0);
        rd_chk(8'h04, 32'h0000_0100, "abort_status");
        spi_xfer(8'h5A, 8, mi);
        rd_chk(8'h08, 32'h0000_005A, "abort_next_byte");

        // Access errors and byte enables
        reg_wr(8'h04, 32'hFFFF_FFFF, 4'hF, 1'b1, "err_wr_status");
        reg_wr(8'h08, 32'hFFFF_FFFF, 4'hF, 1'b1, "err_wr_rxdata");
        rd_err(8'h0C, 1'b1, "err_rd_txdata");
        rd_err(8'h20, 1'b1, "err_rd_unmapped");
        reg_wr(8'h20, 32'hFFFF_FFFF, 4'hF, 1'b1, "err_wr_unmapped");
        rd_err(8'h00, 1'b0, "err_rd_ctrl_ok");
        reg_wr(8'h00, 32'h0000_0F0E, 4'h2, 1'b0, "be_ctrl_wr");
        rd_chk(8'h00, 32'h0000_0001, "be_ctrl_keep");
        reg_wr(8'h0C, 32'h0000_3300, 4'hE, 1'b0, "be_tx_wr");
        rd_chk(8'h04, 32'h0000_0100, "err_status_keep");

        // Reset pulse mid-byte
        reg_wr(8'h00, 32'h11, 4'h1, 1'b0, "rst_ctrl_wr");
        spi_xfer(8'hC3, 8, mi);
        check_val("rst_pre_intr", {31'd0, intr}, 32'd1);
        reg_wr(8'h0C, 32'h80, 4'h1, 1'b0, "rst_tx_wr");
        sclk = 1'b0; sd_in = 1'b1; ss_n = 1'b0;
        wait_clk(HALF);
        check_val("rst_pre_oe", {31'd0, miso_oe}, 32'd1);
        check_val("rst_pre_sd", {31'd0, miso}, 32'd1);
        sclk = 1'b1;
        wait_clk(HALF);
        sclk = 1'b0;
        wait_clk(HALF);
        rd_chk(8'h04, 32'h0000_0801, "rst_pre_busy");
        addr = 8'h00; re = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_val("rstm_sd_oe", {31'd0, miso_oe}, 32'd0);
        check_val("rstm_sd_o", {31'd0, miso}, 32'd0);
        check_val("rstm_intr", {31'd0, intr}, 32'd0);
        check_val("rstm_ctrl", rdata, 32'd0);
        addr = 8'h04;
        #1;
        check_val("rstm_status", rdata, 32'h0000_0100);
        addr = 8'h10;
        #1;
        check_val("rstm_intr_state", rdata, 32'd0);
        re = 1'b0;
        ss_n = 1'b1; sd_in = 1'b0;
        wait_clk(2);
        rst_n = 1'b1;
        wait_clk(4);
        rd_chk(8'h04, 32'h0000_0100, "rst_post_status");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
